// File: rtl/fetch_decode_pkg.sv
// fetch_decode_pkg: fetch FSM states and default boot address
package fetch_decode_pkg;
  typedef enum logic [1:0] {START, REQ, HOLD, DROP} fetch_state_e;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h4000_0060;
endpackage

// File: rtl/rv32i_types.sv
// rv32i_types: RV32I opcode encodings, retirement trace word and immediate extractors
package rv32i_types;
  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011
  } rv32i_opcode;
  typedef struct packed {
    logic [31:0] inst;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic [31:0] rs1_rdata;
    logic [31:0] rs2_rdata;
    logic [31:0] rd_wdata;
    logic [31:0] pc_rdata;
    logic [31:0] pc_wdata;
  } rvfi_word;
  function automatic logic [31:0] imm_i(input logic [31:0] i);
    return {{21{i[31]}}, i[30:20]};
  endfunction
  function automatic logic [31:0] imm_s(input logic [31:0] i);
    return {{21{i[31]}}, i[30:25], i[11:7]};
  endfunction
  function automatic logic [31:0] imm_b(input logic [31:0] i);
    return {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
  endfunction
  function automatic logic [31:0] imm_u(input logic [31:0] i);
    return {i[31:12], 12'h000};
  endfunction
  function automatic logic [31:0] imm_j(input logic [31:0] i);
    return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
  endfunction
endpackage

// File: rtl/tomasula_types.sv
// tomasula_types: decoded control word handed to the instruction queue
package tomasula_types;
  typedef enum logic [3:0] {
    s_op_invalid = 4'd0,
    s_op_reg,
    s_op_imm,
    s_op_load,
    s_op_store,
    s_op_br,
    s_op_lui,
    s_op_auipc,
    s_op_jal,
    s_op_jalr
  } op_t;
  typedef struct packed {
    op_t         opcode;
    logic [2:0]  funct3;
    logic        funct7;
    logic [4:0]  src1_reg;
    logic        src1_valid;
    logic [4:0]  src2_reg;
    logic        src2_valid;
    logic [31:0] src2_data;
    logic [31:0] og_instr;
    logic [31:0] og_pc;
    logic [31:0] pc;
  } ctl_word;
endpackage

// File: rtl/IQ_2_IR.sv
// IQ_2_IR: handshake between the fetch/decode stage and the instruction queue
interface IQ_2_IR;
  logic                   ld_iq;
  logic                   issue_q_full_n;
  tomasula_types::ctl_word control_word;
  rv32i_types::rvfi_word   rvfi;
  modport IR (output ld_iq, control_word, rvfi, input issue_q_full_n);
  modport IQ (input ld_iq, control_word, rvfi, output issue_q_full_n);
endinterface

// File: rtl/fetch_decode_decoder.sv
// rv_decoder: combinational RV32I decode into control/trace words and sequential next PC
module rv_decoder
  import rv32i_types::*;
  import tomasula_types::*;
(
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  output ctl_word     ctl_o,
  output rvfi_word    rvfi_o,
  output logic [31:0] next_pc_o,
  output logic        legal_o
);
  logic use1, use2;
  // classify opcode, pick immediate and source usage, then derive next PC and trace
  always_comb begin
    ctl_o = '0;
    rvfi_o = '0;
    use1 = 1'b0;
    use2 = 1'b0;
    legal_o = 1'b1;
    ctl_o.og_instr = instr_i;
    ctl_o.og_pc = pc_i;
    ctl_o.funct3 = instr_i[14:12];
    case (rv32i_opcode'(instr_i[6:0]))
      op_reg:   begin ctl_o.opcode = s_op_reg; use1 = 1'b1; use2 = 1'b1; ctl_o.funct7 = instr_i[30]; end
      op_imm:   begin ctl_o.opcode = s_op_imm; use1 = 1'b1; ctl_o.src2_data = imm_i(instr_i);
                      ctl_o.funct7 = (instr_i[14:12] == 3'b101) ? instr_i[30] : 1'b0; end
      op_load:  begin ctl_o.opcode = s_op_load; use1 = 1'b1; ctl_o.src2_data = imm_i(instr_i); end
      op_store: begin ctl_o.opcode = s_op_store; use1 = 1'b1; use2 = 1'b1; ctl_o.src2_data = imm_s(instr_i); end
      op_br:    begin ctl_o.opcode = s_op_br; use1 = 1'b1; use2 = 1'b1; ctl_o.src2_data = imm_b(instr_i); end
      op_lui:   begin ctl_o.opcode = s_op_lui; ctl_o.src2_data = imm_u(instr_i); end
      op_auipc: begin ctl_o.opcode = s_op_auipc; ctl_o.src2_data = imm_u(instr_i); end
      op_jal:   begin ctl_o.opcode = s_op_jal; ctl_o.src2_data = imm_j(instr_i); end
      op_jalr:  begin ctl_o.opcode = s_op_jalr; use1 = 1'b1; ctl_o.src2_data = imm_i(instr_i); end
      default:  legal_o = 1'b0;
    endcase
    ctl_o.src1_valid = use1;
    ctl_o.src2_valid = use2;
    ctl_o.src1_reg = use1 ? instr_i[19:15] : 5'd0;
    ctl_o.src2_reg = use2 ? instr_i[24:20] : 5'd0;
    next_pc_o = pc_i + ((ctl_o.opcode == s_op_jal) ? imm_j(instr_i) : 32'd4);
    ctl_o.pc = next_pc_o;
    rvfi_o.inst = instr_i;
    rvfi_o.pc_rdata = pc_i;
    rvfi_o.pc_wdata = next_pc_o;
    rvfi_o.rs1_addr = ctl_o.src1_reg;
    rvfi_o.rs2_addr = ctl_o.src2_reg;
    rvfi_o.rd_addr = (ctl_o.opcode == s_op_store || ctl_o.opcode == s_op_br) ? 5'd0 : instr_i[11:7];
  end
endmodule

// File: rtl/fetch_decode.sv
// fetch_decode: single-outstanding fetch, decode and hold for the instruction queue
module fetch_decode
  import rv32i_types::*;
  import tomasula_types::*;
  import fetch_decode_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n_i,
  output logic        imem_read,
  output logic [31:0] imem_address,
  input  logic        imem_resp,
  input  logic [31:0] imem_rdata,
  input  logic        flush_ip,
  input  logic [31:0] redirect_pc,
  IQ_2_IR.IR          iq_ir_itf,
  input  logic        iq_ack
);
  fetch_state_e state_q, state_d;
  logic [31:0] fetch_addr_q, fetch_addr_d, pc_pending_q, pc_pending_d;
  logic        read_q, read_d;
  ctl_word     cw_q, cw_d, dec_cw;
  rvfi_word    rvfi_q, rvfi_d, dec_rvfi;
  logic [31:0] dec_next_pc;
  logic        dec_legal;

  rv_decoder u_dec (
    .instr_i   (imem_rdata),
    .pc_i      (fetch_addr_q),
    .ctl_o     (dec_cw),
    .rvfi_o    (dec_rvfi),
    .next_pc_o (dec_next_pc),
    .legal_o   (dec_legal)
  );

  assign imem_read = read_q;
  assign imem_address = fetch_addr_q;
  assign iq_ir_itf.ld_iq = (state_q == HOLD) && !flush_ip;
  assign iq_ir_itf.control_word = cw_q;
  assign iq_ir_itf.rvfi = rvfi_q;

  // next-state: a flush always wins; an in-flight request is drained in DROP before redirecting
  always_comb begin
    state_d = state_q;
    fetch_addr_d = fetch_addr_q;
    pc_pending_d = pc_pending_q;
    cw_d = cw_q;
    rvfi_d = rvfi_q;
    case (state_q)
      START: state_d = REQ;
      REQ: begin
        if (imem_resp && flush_ip) fetch_addr_d = redirect_pc;
        else if (imem_resp && dec_legal) begin
          state_d = HOLD;
          cw_d = dec_cw;
          rvfi_d = dec_rvfi;
        end
        else if (imem_resp) fetch_addr_d = dec_next_pc;
        else if (flush_ip) begin
          pc_pending_d = redirect_pc;
          state_d = DROP;
        end
      end
      DROP: begin
        pc_pending_d = flush_ip ? redirect_pc : pc_pending_q;
        if (imem_resp) begin
          fetch_addr_d = pc_pending_d;
          state_d = REQ;
        end
      end
      HOLD: begin
        if (flush_ip || iq_ack) begin
          state_d = REQ;
          fetch_addr_d = flush_ip ? redirect_pc : cw_q.pc;
        end
      end
      default: state_d = START;
    endcase
    read_d = (state_d == REQ) || (state_d == DROP);
  end

  // state, fetch address and held decode registers
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= START;
      fetch_addr_q <= RESET_PC;
      pc_pending_q <= '0;
      read_q <= 1'b0;
      cw_q <= '{opcode: s_op_invalid, default: '0};
      rvfi_q <= '0;
    end else begin
      state_q <= state_d;
      fetch_addr_q <= fetch_addr_d;
      pc_pending_q <= pc_pending_d;
      read_q <= read_d;
      cw_q <= cw_d;
      rvfi_q <= rvfi_d;
    end
  end
endmodule

// File: tb/tb_fetch_decode.sv
// tb_fetch_decode: directed vectors against hand-decoded expectations
module tb_fetch_decode;
  import tomasula_types::*;
  logic        clk = 1'b0;
  logic        reset_n_i = 1'b0;
  logic        imem_read;
  logic [31:0] imem_address;
  logic        imem_resp = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        flush_ip = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        iq_ack;
  int          n_tests = 0;
  int          n_fail = 0;

  IQ_2_IR iq ();

  fetch_decode dut (
    .clk          (clk),
    .reset_n_i    (reset_n_i),
    .imem_read    (imem_read),
    .imem_address (imem_address),
    .imem_resp    (imem_resp),
    .imem_rdata   (imem_rdata),
    .flush_ip     (flush_ip),
    .redirect_pc  (redirect_pc),
    .iq_ir_itf    (iq),
    .iq_ack       (iq_ack)
  );

  assign iq_ack = iq.ld_iq & iq.issue_q_full_n;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    iq.issue_q_full_n = 1'b1;
    repeat (2) step();
    chk("rst_read", 32'(imem_read), 0);
    chk("rst_addr", imem_address, 32'h4000_0060);
    chk("rst_ld", 32'(iq.ld_iq), 0);
    chk("rst_op", 32'(iq.control_word.opcode), 32'(s_op_invalid));
    chk("rst_rvfi", iq.rvfi.inst, 0);
    reset_n_i = 1'b1;
    #1 chk("start_read", 32'(imem_read), 0);
    step();
    chk("req_read", 32'(imem_read), 1);
    chk("req_addr", imem_address, 32'h4000_0060);
    // addi x1,x0,5
    imem_resp = 1'b1; imem_rdata = 32'h0050_0093;
    step();
    imem_resp = 1'b0;
    #1;
    chk("addi_ld", 32'(iq.ld_iq), 1);
    chk("addi_op", 32'(iq.control_word.opcode), 32'(s_op_imm));
    chk("addi_s1", 32'(iq.control_word.src1_reg), 0);
    chk("addi_s1v", 32'(iq.control_word.src1_valid), 1);
    chk("addi_s2v", 32'(iq.control_word.src2_valid), 0);
    chk("addi_imm", iq.control_word.src2_data, 5);
    chk("addi_ogpc", iq.control_word.og_pc, 32'h4000_0060);
    chk("addi_pc", iq.control_word.pc, 32'h4000_0064);
    chk("addi_rd", 32'(iq.rvfi.rd_addr), 1);
    chk("addi_wdata", iq.rvfi.pc_wdata, 32'h4000_0064);
    chk("hold_read", 32'(imem_read), 0);
    step();
    chk("ack_read", 32'(imem_read), 1);
    chk("ack_addr", imem_address, 32'h4000_0064);
    chk("ack_ld", 32'(iq.ld_iq), 0);
    // sub x3,x1,x2 held while the queue is full
    iq.issue_q_full_n = 1'b0;
    imem_resp = 1'b1; imem_rdata = 32'h4020_81B3;
    step();
    imem_resp = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stall_ld", 32'(iq.ld_iq), 1);
      chk("stall_read", 32'(imem_read), 0);
      chk("stall_instr", iq.control_word.og_instr, 32'h4020_81B3);
      step();
    end
    chk("sub_op", 32'(iq.control_word.opcode), 32'(s_op_reg));
    chk("sub_s2", 32'(iq.control_word.src2_reg), 2);
    chk("sub_f7", 32'(iq.control_word.funct7), 1);
    iq.issue_q_full_n = 1'b1;
    #1 chk("release_ack", 32'(iq_ack), 1);
    step();
    chk("rel_addr", imem_address, 32'h4000_0068);
    chk("rel_read", 32'(imem_read), 1);
    // flush while request outstanding, response arrives two cycles later
    flush_ip = 1'b1; redirect_pc = 32'h4000_0100;
    #1 chk("flreq_ld", 32'(iq.ld_iq), 0);
    step();
    flush_ip = 1'b0;
    chk("drop_read", 32'(imem_read), 1);
    chk("drop_addr", imem_address, 32'h4000_0068);
    step();
    chk("drop_ld", 32'(iq.ld_iq), 0);
    imem_resp = 1'b1; imem_rdata = 32'h0050_0093;
    step();
    imem_resp = 1'b0;
    chk("drop_done_ld", 32'(iq.ld_iq), 0);
    chk("redir_read", 32'(imem_read), 1);
    chk("redir_addr", imem_address, 32'h4000_0100);
    // jal x0,+16
    imem_resp = 1'b1; imem_rdata = 32'h0100_006F;
    step();
    imem_resp = 1'b0;
    chk("jal_ld", 32'(iq.ld_iq), 1);
    chk("jal_op", 32'(iq.control_word.opcode), 32'(s_op_jal));
    chk("jal_pc", iq.control_word.pc, 32'h4000_0110);
    chk("jal_imm", iq.control_word.src2_data, 16);
    step();
    chk("jal_fetch", imem_address, 32'h4000_0110);
    chk("jal_read", 32'(imem_read), 1);
    // sw x2,8(x1) then flushed while held
    iq.issue_q_full_n = 1'b0;
    imem_resp = 1'b1; imem_rdata = 32'h0020_A423;
    step();
    imem_resp = 1'b0;
    chk("sw_op", 32'(iq.control_word.opcode), 32'(s_op_store));
    chk("sw_imm", iq.control_word.src2_data, 8);
    chk("sw_s2v", 32'(iq.control_word.src2_valid), 1);
    chk("sw_rd", 32'(iq.rvfi.rd_addr), 0);
    chk("sw_ogpc", iq.control_word.og_pc, 32'h4000_0110);
    iq.issue_q_full_n = 1'b1;
    flush_ip = 1'b1; redirect_pc = 32'h4000_0300;
    #1;
    chk("flhold_ld", 32'(iq.ld_iq), 0);
    chk("flhold_ack", 32'(iq_ack), 0);
    step();
    flush_ip = 1'b0;
    chk("flhold_addr", imem_address, 32'h4000_0300);
    chk("flhold_read", 32'(imem_read), 1);
    // illegal opcode is skipped
    imem_resp = 1'b1; imem_rdata = 32'hFFFF_FFFF;
    step();
    imem_resp = 1'b0;
    chk("ill_ld", 32'(iq.ld_iq), 0);
    chk("ill_read", 32'(imem_read), 1);
    chk("ill_addr", imem_address, 32'h4000_0304);
    // beq x1,x2,-8 predicted not-taken
    imem_resp = 1'b1; imem_rdata = 32'hFE20_8CE3;
    step();
    imem_resp = 1'b0;
    chk("br_op", 32'(iq.control_word.opcode), 32'(s_op_br));
    chk("br_imm", iq.control_word.src2_data, 32'hFFFF_FFF8);
    chk("br_pc", iq.control_word.pc, 32'h4000_0308);
    chk("br_rd", 32'(iq.rvfi.rd_addr), 0);
    chk("br_s1", 32'(iq.control_word.src1_reg), 1);
    step();
    chk("br_fetch", imem_address, 32'h4000_0308);
    // flush coincident with response in REQ
    flush_ip = 1'b1; redirect_pc = 32'h4000_0400;
    imem_resp = 1'b1; imem_rdata = 32'h0050_0093;
    step();
    flush_ip = 1'b0; imem_resp = 1'b0;
    chk("flresp_ld", 32'(iq.ld_iq), 0);
    chk("flresp_addr", imem_address, 32'h4000_0400);
    chk("flresp_read", 32'(imem_read), 1);
    // asynchronous reset mid-request, stray response in START ignored
    reset_n_i = 1'b0;
    #1;
    chk("arst_read", 32'(imem_read), 0);
    chk("arst_addr", imem_address, 32'h4000_0060);
    chk("arst_op", 32'(iq.control_word.opcode), 32'(s_op_invalid));
    step();
    reset_n_i = 1'b1;
    imem_resp = 1'b1; imem_rdata = 32'h0050_0093;
    step();
    imem_resp = 1'b0;
    chk("stray_ld", 32'(iq.ld_iq), 0);
    chk("stray_read", 32'(imem_read), 1);
    chk("stray_addr", imem_address, 32'h4000_0060);
    step();
    chk("stray_ld2", 32'(iq.ld_iq), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_decode.md
# fetch_decode

Front-end stage directly upstream of the instruction queue. It fetches one instruction at a time from the instruction memory port, decodes it into a `tomasula_types::ctl_word` plus a `rv32i_types::rvfi_word`, and holds the result until the instruction queue accepts it over the `IQ_2_IR` handshake. It owns the architectural fetch PC and applies static not-taken prediction, with JAL redirected at decode. A ROB flush cancels any outstanding request or held word and restarts fetch at the redirect PC.

## Interface
- `RESET_PC`, default 32'h4000_0060: first fetch address after reset.
- `clk` in 1: single clock, rising edge.
- `reset_n_i` in 1: asynchronous, active-low reset.
- `imem_read` in/out: out 1. Registered read request, held until `imem_resp`.
- `imem_address` out 32: registered, stable while `imem_read` is high.
- `imem_resp` in 1: one-cycle response strobe that completes the request.
- `imem_rdata` in 32: instruction, valid with `imem_resp`.
- `flush_ip` in 1: ROB flush strobe.
- `redirect_pc` in 32: restart PC, valid with `flush_ip`.
- `iq_ir_itf` `IQ_2_IR` (IR side): drives `ld_iq`, `control_word`, `rvfi`; reads `issue_q_full_n`.
- `iq_ack` in 1: IQ accept, combinational from `ld_iq & issue_q_full_n`.

## Operation
- States: START, REQ, HOLD, DROP. Reset: START.
- START: unconditionally go to REQ.
- REQ: `imem_read`=1 at `fetch_addr`.
  - `imem_resp` without `flush_ip`: decode `imem_rdata` into the held registers.
    - Legal opcode: go to HOLD.
    - Illegal opcode: drop it, set `fetch_addr`+=4, stay REQ (new request next cycle).
  - `imem_resp` with `flush_ip`: discard data, set `fetch_addr`=`redirect_pc`, stay REQ.
  - `flush_ip` without `imem_resp`: set `pc_pending`=`redirect_pc`, go to DROP.
- DROP: keep `imem_read`=1 at the old `imem_address` until `imem_resp`.
  - On `imem_resp`: discard data, set `fetch_addr`=`pc_pending`, go to REQ.
  - A further `flush_ip` overwrites `pc_pending`.
- HOLD: `ld_iq` = ~`flush_ip`. Held word stays constant.
  - `iq_ack`: set `fetch_addr` = held `pc` field, go to REQ.
  - `flush_ip`: discard the word, set `fetch_addr`=`redirect_pc`, go to REQ. Flush has priority over ack.
- Decode into `ctl_word`:
  - `og_instr`=instr, `og_pc`=fetch PC, `funct3`=instr[14:12].
  - reg (0110011): `s_op_reg`, src1=rs1 valid, src2=rs2 valid, `src2_data`=0, `funct7`=instr[30].
  - imm (0010011): `s_op_imm`, src1 valid, src2 invalid, `src2_data`=I-imm; `funct7`=instr[30] only when funct3=101, else 0.
  - load: `s_op_load`, src1 valid, `src2_data`=I-imm.
  - store: `s_op_store`, src1 and src2 valid, `src2_data`=S-imm.
  - branch: `s_op_br`, src1 and src2 valid, `src2_data`=B-imm.
  - lui / auipc / jal / jalr: `s_op_lui` / `s_op_auipc` / `s_op_jal` / `s_op_jalr`; `src2_data`=U-, U-, J-, I-imm respectively; jalr has src1 valid.
  - Unused src regs are 0 with valid=0.
- Next-PC (`pc` field): jal = `og_pc`+J-imm; all others `og_pc`+4 (branches and jalr predicted not-taken/sequential). Arithmetic is mod 2^32; wrap is not flagged.
- `rvfi`: `inst`, `pc_rdata`=`og_pc`, `pc_wdata`=`pc` field, `rs1_addr`, `rs2_addr`, `rd_addr` (0 for store/branch). All other fields 0.

## Timing
- Reset values:
  - `imem_read`=0, `imem_address`=`RESET_PC`.
  - `ld_iq`=0.
  - `control_word` = `s_op_invalid`, all other fields 0.
  - `rvfi`=0.
- First `imem_read` is asserted in the second cycle after `reset_n_i` rises (START, then REQ).
- `imem_resp` in cycle N gives `ld_iq`=1 in N+1. If acked in N+1, the next `imem_read` is in N+2. Throughput is at most 1 instruction per 2 cycles plus memory latency.
- `control_word`/`rvfi` are registered and stable for every cycle `ld_iq` is high.
- Flush takes effect at the clock edge where it is sampled. `ld_iq` is combinationally low in the flush cycle, so no enqueue can occur.
- Reset asserted mid-request: all state returns to reset values immediately. Any later stray `imem_resp` in START is ignored.

## Structure
- `tomasula_types` gains `s_op_lui`, `s_op_auipc`, `s_op_jal`, `s_op_jalr` if they are absent.
- `rv32i_types` supplies the opcode enum and immediate-format constants.
- One combinational sub-module: `rv_decoder` (instr, pc → `ctl_word`, `rvfi_word`, `next_pc`, `legal`).
- The FSM, `fetch_addr`, `pc_pending` and held registers stay in `fetch_decode`.

## Test plan
- Reset release → `imem_read` rises on the 2nd cycle with address 0x4000_0060. During reset, `ld_iq`=0 and `control_word.opcode`=`s_op_invalid`.
- Response 0x0050_0093 (addi x1,x0,5) at 0x4000_0060, `issue_q_full_n`=1 → next cycle `ld_iq`=1 with `s_op_imm`, `src1_reg`=0 valid, `src2_data`=5, `og_pc`=0x4000_0060, `pc`=0x4000_0064. The following request is at 0x4000_0064.
- `issue_q_full_n`=0 for 3 cycles while in HOLD → `ld_iq` held, word unchanged, `imem_read`=0. Release → ack, then fetch 0x4000_0064.
- jal x0,+16 at 0x4000_0100 → `pc`=0x4000_0110, next `imem_address`=0x4000_0110.
- `flush_ip` with `redirect_pc`=0x4000_0200 two cycles before a pending `imem_resp` → no `ld_iq`, response discarded, next request at 0x4000_0200.
- `flush_ip` in HOLD with `issue_q_full_n`=1 → `ld_iq`=0 that cycle (no ack). Next request is at `redirect_pc`. Illegal opcode 0xFFFF_FFFF → no `ld_iq`, next fetch at PC+4.
